// File: rtl/mark_stepper_if.sv
// Handshake between mark_stepper and its distance checker.
interface mark_stepper_if #(
   parameter int VW       = 8,
   parameter int MAXVALUE = 32
);
   logic [VW-1:0]       val;
   logic                startCompute;
   logic                cleanup;
   logic                resultsReady;
   logic                good;
   logic [MAXVALUE-1:0] pdHash;

   modport master (
      output val, startCompute, cleanup,
      input  resultsReady, good, pdHash
   );

   modport slave (
      input  val, startCompute, cleanup,
      output resultsReady, good, pdHash
   );
endinterface

// File: rtl/mark_stepper.sv
// Per-level mark search: proposes candidates to the distance checker and commits the first clash-free one.
//
// state  | meaning
// IDLE   | waiting for start
// ISSUE  | startCompute high for the current candidate
// ARM    | checker still shows its idle resultsReady; ignore it
// WAIT   | waiting for the checker verdict
// PLACED | mark committed, outputs held until resume or abort
// EXH    | one-cycle exhaustion report
module mark_stepper #(
   parameter int VW       = 8,
   parameter int MAXVALUE = 32
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                start,
   input  logic                resume,
   input  logic                abort,
   input  logic [VW-1:0]       startValue,
   input  logic [VW-1:0]       limit,
   mark_stepper_if.master      chk,
   output logic [MAXVALUE-1:0] dist_mask,
   output logic [VW-1:0]       mark_out,
   output logic [VW-1:0]       next_start,
   output logic                placed,
   output logic                exhausted,
   output logic                busy
);

   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_ARM, S_WAIT, S_PLACED, S_EXH
   } state_t;

   state_t              state_q, state_d;
   logic [VW-1:0]       val_q, val_d;
   logic [VW-1:0]       mark_q, mark_d;
   logic [VW-1:0]       next_q, next_d;
   logic [MAXVALUE-1:0] mask_q, mask_d;
   logic                sc_q, sc_d;
   logic                cl_q, cl_d;
   logic                pl_q, pl_d;
   logic                ex_q, ex_d;
   logic                busy_q, busy_d;

   // One extra bit so a candidate of 2^VW-1 compares past limit instead of wrapping.
   logic [VW:0] val_inc, mark_inc, limit_x;

   assign val_inc  = {1'b0, val_q}  + {{VW{1'b0}}, 1'b1};
   assign mark_inc = {1'b0, mark_q} + {{VW{1'b0}}, 1'b1};
   assign limit_x  = {1'b0, limit};

   always_comb begin
      state_d = state_q;
      val_d   = val_q;
      mark_d  = mark_q;
      next_d  = next_q;
      mask_d  = mask_q;
      pl_d    = 1'b0;
      cl_d    = 1'b0;

      if (abort) begin
         state_d = S_IDLE;
         mask_d  = '0;
         cl_d    = 1'b1;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  val_d   = startValue;
                  state_d = ({1'b0, startValue} >= limit_x) ? S_EXH : S_ISSUE;
               end
            end
            S_ISSUE: state_d = S_ARM;
            S_ARM:   state_d = S_WAIT;
            S_WAIT: begin
               if (chk.resultsReady) begin
                  if (chk.good) begin
                     mask_d  = chk.pdHash;
                     mark_d  = val_q;
                     next_d  = val_inc[VW-1:0];
                     pl_d    = 1'b1;
                     state_d = S_PLACED;
                  end else if (val_inc >= limit_x) begin
                     state_d = S_EXH;
                  end else begin
                     val_d   = val_inc[VW-1:0];
                     state_d = S_ISSUE;
                  end
               end
            end
            S_PLACED: begin
               if (resume) begin
                  mask_d = '0;
                  if (mark_inc >= limit_x) begin
                     state_d = S_EXH;
                  end else begin
                     val_d   = mark_inc[VW-1:0];
                     state_d = S_ISSUE;
                  end
               end
            end
            S_EXH:   state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end

      // Output flags follow the state being entered so they are registered with it.
      ex_d   = (state_d == S_EXH);
      sc_d   = (state_d == S_ISSUE);
      busy_d = (state_d == S_ISSUE) || (state_d == S_ARM) ||
               (state_d == S_WAIT)  || (state_d == S_EXH);
      if (state_d == S_EXH) mask_d = '0;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         val_q   <= '0;
         mark_q  <= '0;
         next_q  <= '0;
         mask_q  <= '0;
         sc_q    <= 1'b0;
         cl_q    <= 1'b0;
         pl_q    <= 1'b0;
         ex_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         val_q   <= val_d;
         mark_q  <= mark_d;
         next_q  <= next_d;
         mask_q  <= mask_d;
         sc_q    <= sc_d;
         cl_q    <= cl_d;
         pl_q    <= pl_d;
         ex_q    <= ex_d;
         busy_q  <= busy_d;
      end
   end

   assign chk.val          = val_q;
   assign chk.startCompute = sc_q;
   assign chk.cleanup      = cl_q;
   assign dist_mask        = mask_q;
   assign mark_out         = mark_q;
   assign next_start       = next_q;
   assign placed           = pl_q;
   assign exhausted        = ex_q;
   assign busy             = busy_q;

endmodule

// File: tb/tb_mark_stepper.sv
// Directed bench for mark_stepper with a 3-cycle behavioural distance checker.
module tb_mark_stepper;
   localparam int VW = 8;
   localparam int MV = 32;
   localparam logic [8:0] NONE = 9'h1FF;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          resume = 1'b0;
   logic          abort = 1'b0;
   logic [VW-1:0] startValue = '0;
   logic [VW-1:0] limit = '0;
   logic [MV-1:0] dist_mask;
   logic [VW-1:0] mark_out, next_start;
   logic          placed, exhausted, busy;

   mark_stepper_if #(.VW(VW), .MAXVALUE(MV)) chk ();

   mark_stepper #(.VW(VW), .MAXVALUE(MV)) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .resume     (resume),
      .abort      (abort),
      .startValue (startValue),
      .limit      (limit),
      .chk        (chk),
      .dist_mask  (dist_mask),
      .mark_out   (mark_out),
      .next_start (next_start),
      .placed     (placed),
      .exhausted  (exhausted),
      .busy       (busy)
   );

   always #5 clock = ~clock;

   // Checker model: candidates >= first_good are clash-free; pdHash marks bit val[4:0].
   logic [8:0]    first_good = NONE;
   int unsigned   ck_cnt;
   logic [VW-1:0] ck_val;

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         chk.resultsReady <= 1'b1;
         chk.good         <= 1'b0;
         chk.pdHash       <= '0;
         ck_cnt           <= 0;
         ck_val           <= '0;
      end else if (chk.startCompute) begin
         chk.resultsReady <= 1'b0;
         ck_cnt           <= 3;
         ck_val           <= chk.val;
      end else if (ck_cnt != 0) begin
         ck_cnt <= ck_cnt - 1;
         if (ck_cnt == 1) begin
            chk.resultsReady <= 1'b1;
            chk.good         <= ({1'b0, ck_val} >= first_good);
            chk.pdHash       <= 32'h1 << ck_val[4:0];
         end
      end
   end

   typedef struct {
      logic [7:0]  sv;
      logic [7:0]  lim;
      logic [8:0]  fg;
      int          exp_sc;
      int          exp_pl;
      int          exp_ex;
      logic [7:0]  exp_mark;
      logic [7:0]  exp_next;
      logic [7:0]  exp_val;
      logic [31:0] exp_mask;
      int          exp_lat;
   } vec_t;

   vec_t vecs[7];

   int checks = 0;
   int errors = 0;
   int sc_cnt = 0, pl_cnt = 0, ex_cnt = 0, cl_cnt = 0;
   logic [7:0] last_sc_val = '0;

   task automatic step();
      @(negedge clock);
      if (chk.startCompute) begin
         sc_cnt++;
         last_sc_val = chk.val;
      end
      if (placed)      pl_cnt++;
      if (exhausted)   ex_cnt++;
      if (chk.cleanup) cl_cnt++;
   endtask

   task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Wait for placed/exhausted; returns cycles counted from the first sample after the trigger.
   task automatic wait_done(output int lat);
      lat = 0;
      while (!(placed || exhausted) && lat < 200) begin
         step();
         lat++;
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int sc0, pl0, ex0, lat;
      abort = 1'b1; step(); abort = 1'b0; step(); step();
      startValue = v.sv; limit = v.lim; first_good = v.fg;
      sc0 = sc_cnt; pl0 = pl_cnt; ex0 = ex_cnt;
      start = 1'b1; step(); start = 1'b0;
      wait_done(lat);
      chk_eq($sformatf("v%0d latency", idx), lat, v.exp_lat);
      chk_eq($sformatf("v%0d mark_out", idx), mark_out, v.exp_mark);
      chk_eq($sformatf("v%0d next_start", idx), next_start, v.exp_next);
      chk_eq($sformatf("v%0d dist_mask", idx), dist_mask, v.exp_mask);
      chk_eq($sformatf("v%0d val", idx), chk.val, v.exp_val);
      step();
      chk_eq($sformatf("v%0d startCompute count", idx), sc_cnt - sc0, v.exp_sc);
      chk_eq($sformatf("v%0d placed count", idx), pl_cnt - pl0, v.exp_pl);
      chk_eq($sformatf("v%0d exhausted count", idx), ex_cnt - ex0, v.exp_ex);
      if (v.exp_sc > 0) chk_eq($sformatf("v%0d last candidate", idx), last_sc_val, v.exp_val);
   endtask

   initial begin
      int lat, pl0, cl0, sc0;

      //         sv    lim   fg    sc pl ex mark next val   mask         lat
      vecs[0] = '{8'd3,   8'd10,  9'd3, 1, 1, 0, 8'd3, 8'd4, 8'd3,   32'h8,  5};
      vecs[1] = '{8'd3,   8'd10,  9'd5, 3, 1, 0, 8'd5, 8'd6, 8'd5,   32'h20, 15};
      vecs[2] = '{8'd9,   8'd10,  NONE, 1, 0, 1, 8'd5, 8'd6, 8'd9,   32'h0,  5};
      vecs[3] = '{8'd10,  8'd10,  NONE, 0, 0, 1, 8'd5, 8'd6, 8'd10,  32'h0,  0};
      vecs[4] = '{8'd254, 8'd255, NONE, 1, 0, 1, 8'd5, 8'd6, 8'd254, 32'h0,  5};
      vecs[5] = '{8'd0,   8'd255, 9'd0, 1, 1, 0, 8'd0, 8'd1, 8'd0,   32'h1,  5};
      vecs[6] = '{8'd255, 8'd255, NONE, 0, 0, 1, 8'd0, 8'd1, 8'd255, 32'h0,  0};

      #1 reset = 1'b0;
      step(); step();
      chk_eq("reset val", chk.val, 0);
      chk_eq("reset startCompute", chk.startCompute, 0);
      chk_eq("reset cleanup", chk.cleanup, 0);
      chk_eq("reset dist_mask", dist_mask, 0);
      chk_eq("reset mark_out", mark_out, 0);
      chk_eq("reset next_start", next_start, 0);
      chk_eq("reset pulses", {placed, exhausted, busy}, 0);
      reset = 1'b1;
      step();

      for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

      // Backtrack from a mark committed at 5.
      run_vec(vecs[1], 7);
      resume = 1'b1; step(); resume = 1'b0;
      chk_eq("resume dist_mask", dist_mask, 0);
      chk_eq("resume startCompute", chk.startCompute, 1);
      chk_eq("resume val", chk.val, 6);
      chk_eq("resume busy", busy, 1);
      wait_done(lat);
      chk_eq("resume latency", lat, 5);
      chk_eq("resume placed", placed, 1);
      chk_eq("resume mark_out", mark_out, 6);
      chk_eq("resume next_start", next_start, 7);
      chk_eq("resume dist_mask placed", dist_mask, 32'h40);
      step();
      limit = 8'd7;
      sc0 = sc_cnt;
      resume = 1'b1; step(); resume = 1'b0;
      chk_eq("resume exh exhausted", exhausted, 1);
      chk_eq("resume exh startCompute", sc_cnt - sc0, 0);
      chk_eq("resume exh dist_mask", dist_mask, 0);
      chk_eq("resume exh val", chk.val, 6);
      step();
      chk_eq("resume exh pulse width", exhausted, 0);
      chk_eq("resume exh idle busy", busy, 0);
      chk_eq("resume exh mark kept", mark_out, 6);

      // Abort while waiting on a verdict that would be good.
      startValue = 8'd3; limit = 8'd10; first_good = 9'd3;
      start = 1'b1; step(); start = 1'b0;
      step(); step();
      chk_eq("pre-abort busy", busy, 1);
      pl0 = pl_cnt; cl0 = cl_cnt;
      abort = 1'b1; step(); abort = 1'b0;
      chk_eq("abort cleanup", chk.cleanup, 1);
      chk_eq("abort busy", busy, 0);
      chk_eq("abort startCompute", chk.startCompute, 0);
      chk_eq("abort dist_mask", dist_mask, 0);
      chk_eq("abort mark kept", mark_out, 6);
      chk_eq("abort val kept", chk.val, 3);
      for (int i = 0; i < 10; i++) step();
      chk_eq("abort no placed", pl_cnt - pl0, 0);
      chk_eq("abort cleanup width", cl_cnt - cl0, 1);
      chk_eq("abort still idle", busy, 0);

      // Asynchronous reset during WAIT.
      run_vec(vecs[0], 8);
      resume = 1'b1; step(); resume = 1'b0;
      step(); step();
      chk_eq("pre-reset busy", busy, 1);
      chk_eq("pre-reset val", chk.val, 4);
      #2 reset = 1'b0;
      #1;
      chk_eq("async reset val", chk.val, 0);
      chk_eq("async reset mark_out", mark_out, 0);
      chk_eq("async reset next_start", next_start, 0);
      chk_eq("async reset dist_mask", dist_mask, 0);
      chk_eq("async reset flags",
             {chk.startCompute, chk.cleanup, placed, exhausted, busy}, 0);
      step(); step();
      reset = 1'b1;
      pl0 = pl_cnt;
      for (int i = 0; i < 10; i++) step();
      chk_eq("post-reset no placed", pl_cnt - pl0, 0);
      chk_eq("post-reset idle", busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mark_stepper.md
# mark_stepper

Per-level search controller that sits directly upstream of `distance_check` and drives its `val`/`startCompute`/`cleanup` inputs. Starting from a supplied start value, it proposes successive candidate positions for one mark, waits for the checker's verdict, and commits the first clash-free position. It then reports the newly contributed distance mask, or reports exhaustion when the candidate reaches `limit`. It also supports backtracking, which resumes the search past the committed position, and abort.

## Interface
Parameters:
- `VW`, 8, position value width (candidate, limit, marks)
- `MAXVALUE`, 32, distance hash width; bit d (1-based) set ⇔ distance d used

Ports:
- `clock`  in  1  system clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  pulse: begin search for this level (ignored unless IDLE)
- `resume`  in  1  pulse: backtrack into this level, continue from committed value+1 (ignored unless PLACED)
- `abort`  in  1  pulse: drop everything, return to IDLE (any state)
- `startValue`  in  VW  first candidate to try
- `limit`  in  VW  candidates must be strictly below
- `resultsReady`  in  1  from checker
- `good`  in  1  from checker, valid when `resultsReady`
- `pdHash`  in  MAXVALUE  from checker, distances added by accepted candidate
- `val`  out  VW  current candidate to checker
- `startCompute`  out  1  one-cycle request to checker
- `cleanup`  out  1  one-cycle checker flush, issued on abort
- `dist_mask`  out  MAXVALUE  distances contributed by committed mark, 0 unless PLACED
- `mark_out`  out  VW  committed position
- `next_start`  out  VW  `mark_out`+1, start value for next level
- `placed`  out  1  one-cycle pulse on commit
- `exhausted`  out  1  one-cycle pulse when search fails
- `busy`  out  1  high in ISSUE, ARM, WAIT, EXH

## Operation
- States: IDLE, ISSUE, ARM, WAIT, PLACED, EXH.
- IDLE:
  - `start` loads `val`←`startValue`.
  - If `startValue` ≥ `limit`, go to EXH; otherwise go to ISSUE.
- ISSUE: `startCompute`=1 for exactly one cycle, then go to ARM.
- ARM: one cycle that ignores `resultsReady`, which still reads 1 from the checker's idle state. Then go to WAIT.
- WAIT: wait indefinitely for `resultsReady`=1.
  - If `good`=1: `dist_mask`←`pdHash`, `mark_out`←`val`, `next_start`←`val`+1, pulse `placed`, go to PLACED.
  - If `good`=0: compute s=`val`+1 at VW+1 bits. If s ≥ `limit`, go to EXH with `val` unchanged. Otherwise `val`←s[VW-1:0] and go to ISSUE.
- PLACED: hold all outputs.
  - On `resume`: `dist_mask`←0 and compute s=`mark_out`+1 at VW+1 bits. If s ≥ `limit`, go to EXH. Otherwise `val`←s and go to ISSUE.
- EXH: pulse `exhausted` and force `dist_mask`=0, then go to IDLE.
- `abort` in any state has top priority over `start`, `resume` and checker results:
  - Go to IDLE with `dist_mask`←0, `startCompute`←0 and `cleanup`=1 for one cycle.
  - `mark_out`, `next_start` and `val` keep their values.
- The VW+1-bit compare means `val`=2^VW−1 never wraps to 0.
- `start` while not IDLE and `resume` while not PLACED have no effect.

## Timing
- All outputs are registered.
- Reset values: state IDLE, `val` 0, `startCompute` 0, `cleanup` 0, `dist_mask` 0, `mark_out` 0, `next_start` 0, `placed` 0, `exhausted` 0, `busy` 0.
- Reset is asynchronous. Asserting it mid-search clears all outputs immediately, and any in-flight checker result is then ignored.
- `start` sampled at edge E0 gives `startCompute` high E0→E1, ARM E1→E2, WAIT from E2.
- `resultsReady`&`good` sampled at edge Ek gives `placed`, `dist_mask`, `mark_out` and `next_start` updated after Ek.
- A failed candidate at Ek gives the next `startCompute` high Ek→Ek+1. Per-candidate overhead is 2 cycles plus checker latency.
- Exhaustion from WAIT: `exhausted` goes high the cycle after the failing verdict.
- Direct exhaustion from IDLE: `exhausted` goes high 1 cycle after `start`, with no `startCompute`.
- `resume` at E gives `dist_mask`=0 after E and `startCompute` high after E.
- `abort` at E gives `cleanup` high E→E+1 and IDLE after E.

## Test plan
Use VW=8, MAXVALUE=32, with a behavioural checker of 3-cycle latency.

- `start`, `startValue`=3, `limit`=10, checker good with pdHash=0x8 → exactly one `startCompute` (`val`=3), `placed` pulse, `mark_out`=3, `next_start`=4, `dist_mask`=0x8.
- Checker bad for 3 and 4, good for 5 → three `startCompute` pulses with `val` 3,4,5; `mark_out`=5; no `exhausted`.
- `startValue`=9, `limit`=10, bad → exhausted pulse one cycle after verdict, `dist_mask`=0.
- `startValue`=10, `limit`=10 → `exhausted` with no `startCompute`.
- `startValue`=254, `limit`=255, bad → exhausted, `val` stays 254 (no wrap).
- Placed at 5, `resume` → `dist_mask`=0 next cycle, `startCompute` with `val`=6; `resume` with `limit`=6 → `exhausted`.
- `abort` during WAIT, then checker good → `cleanup` pulse, IDLE, no `placed`, `dist_mask`=0. Then drop `reset` during WAIT → all outputs 0 without waiting for a clock edge.
